// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : EX-stage branch/jump resolution. Accepts an issue, waits one
//                cycle for the registered compare result from cmp, decides the
//                branch direction and checks it against the front-end
//                prediction. On a mispredict it pulses flush and holds a
//                redirect request to fetch until fetch accepts it. Keeps
//                saturating branch and mispredict counters for the perf CSRs.
//
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                in_valid/in_ready    - issue handshake
//                in_pc, in_imm        - branch PC and sign-extended offset
//                in_pred_taken        - front-end prediction
//                in_is_jump           - unconditional jump (cmp ignored)
//                cmp_result           - condition, valid cycle after issue
//                done_valid/done_taken- resolution pulse and direction
//                flush                - one-cycle mispredict pulse
//                redirect_valid/_ready/_pc - fetch redirect handshake
//                branch_count, mispredict_count - saturating perf counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int COUNT_WIDTH = 16,
    parameter int INSN_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_imm,
    input  logic                   in_pred_taken,
    input  logic                   in_is_jump,
    input  logic                   cmp_result,
    output logic                   done_valid,
    output logic                   done_taken,
    output logic                   flush,
    output logic                   redirect_valid,
    input  logic                   redirect_ready,
    output logic [31:0]            redirect_pc,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    localparam logic [31:0]            c_insn_bytes = 32'(INSN_BYTES);
    localparam logic [COUNT_WIDTH-1:0] c_count_max  = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RESOLVE  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Issue-time snapshot of the branch; the issuer may change its inputs
    // once the issue has been accepted.
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic        r_pred_taken;
    logic        r_is_jump;

    logic [31:0]            r_redirect_pc;
    logic [COUNT_WIDTH-1:0] r_branch_count;
    logic [COUNT_WIDTH-1:0] r_mispredict_count;

    logic        w_taken;
    logic        w_mispredict;
    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic        w_in_idle;
    logic        w_in_resolve;
    logic        w_in_redirect;

    // ------------------------------------------------------------------------
    // Direction / target decision. cmp_result is itself a registered output
    // of cmp, so using it here does not create a long combinational path.
    // ------------------------------------------------------------------------
    always_comb begin
        w_taken      = r_is_jump | cmp_result;
        w_mispredict = (w_taken != r_pred_taken);
        // 32-bit add wraps naturally; bit 0 of a fetch address is always 0.
        w_sum        = w_taken ? (r_pc + r_imm) : (r_pc + c_insn_bytes);
        w_target     = w_sum & ~32'd1;
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode. Handshake outputs come only from the
    // state register (and reset), never from in_valid or redirect_ready.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_in_idle     = 1'b0;
        w_in_resolve  = 1'b0;
        w_in_redirect = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_idle = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                w_in_resolve = 1'b1;
                w_state_next = w_mispredict ? S_REDIRECT : S_IDLE;
            end
            S_REDIRECT: begin
                w_in_redirect = 1'b1;
                if (redirect_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        in_ready       = w_in_idle     & ~reset;
        done_valid     = w_in_resolve  & ~reset;
        done_taken     = w_in_resolve  & ~reset & w_taken;
        flush          = w_in_resolve  & ~reset & w_mispredict;
        redirect_valid = w_in_redirect & ~reset;
    end

    // ------------------------------------------------------------------------
    // State, snapshot, redirect address and counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_pc               <= '0;
            r_imm              <= '0;
            r_pred_taken       <= 1'b0;
            r_is_jump          <= 1'b0;
            r_redirect_pc      <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_in_idle && in_valid) begin
                r_pc         <= in_pc;
                r_imm        <= in_imm;
                r_pred_taken <= in_pred_taken;
                r_is_jump    <= in_is_jump;
            end

            if (w_in_resolve) begin
                if (r_branch_count != c_count_max) begin
                    r_branch_count <= r_branch_count + 1'b1;
                end
                if (w_mispredict) begin
                    r_redirect_pc <= w_target;
                    if (r_mispredict_count != c_count_max) begin
                        r_mispredict_count <= r_mispredict_count + 1'b1;
                    end
                end
            end
        end
    end

    assign redirect_pc      = r_redirect_pc;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Self-checking bench for branch_resolve. Directed table of
//                branch cases, randomized branches against a behavioural
//                model, reset during a pending redirect, counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_imm;
    logic          in_pred_taken;
    logic          in_is_jump;
    logic          cmp_result;
    logic          done_valid;
    logic          done_taken;
    logic          flush;
    logic          redirect_valid;
    logic          redirect_ready;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    branch_resolve #(.COUNT_WIDTH(CW), .INSN_BYTES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_imm           (in_imm),
        .in_pred_taken    (in_pred_taken),
        .in_is_jump       (in_is_jump),
        .cmp_result       (cmp_result),
        .done_valid       (done_valid),
        .done_taken       (done_taken),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_ready   (redirect_ready),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        jmp;
        logic        cmp;
        int          hold;
        logic        exp_taken;
        logic        exp_flush;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural branch rules in plain arithmetic.
    task automatic model(input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                         input logic jmp, input logic cmp,
                         output logic taken, output logic mis, output logic [31:0] tgt);
        longint unsigned t;
        taken = jmp || cmp;
        mis   = (taken != pred);
        t     = taken ? (longint'(pc) + longint'(imm)) : (longint'(pc) + 4);
        t     = t % 64'h1_0000_0000;
        tgt   = 32'(t - (t % 2));
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_branch(input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                              input logic jmp, input logic cmp, input int hold,
                              input logic exp_taken, input logic exp_flush,
                              input logic [31:0] exp_rpc, input string tag);
        #1;
        check({tag, " in_ready idle"}, in_ready, 1'b1);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = pred;
        in_is_jump     = jmp;
        redirect_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        // RESOLVE: scramble issue inputs and keep in_valid high; both must be ignored.
        in_pc          = $urandom;
        in_imm         = $urandom;
        in_pred_taken  = 1'($urandom_range(0, 1));
        in_is_jump     = 1'($urandom_range(0, 1));
        redirect_ready = 1'($urandom_range(0, 1));
        cmp_result     = cmp;
        #1;
        check({tag, " done_valid"}, done_valid, 1'b1);
        check({tag, " done_taken"}, done_taken, exp_taken);
        check({tag, " flush"}, flush, exp_flush);
        check({tag, " in_ready resolve"}, in_ready, 1'b0);
        check({tag, " redirect_valid resolve"}, redirect_valid, 1'b0);
        exp_br = (exp_br < CMAX) ? exp_br + 1 : CMAX;
        if (exp_flush) exp_mis = (exp_mis < CMAX) ? exp_mis + 1 : CMAX;
        @(posedge clk);
        @(negedge clk);
        cmp_result = 1'($urandom_range(0, 1));
        if (exp_flush) begin
            for (int k = 0; k < hold; k++) begin
                redirect_ready = 1'b0;
                #1;
                check({tag, " redirect_valid hold"}, redirect_valid, 1'b1);
                check({tag, " redirect_pc hold"}, redirect_pc, exp_rpc);
                check({tag, " in_ready redirect"}, in_ready, 1'b0);
                check({tag, " done_valid redirect"}, done_valid, 1'b0);
                @(posedge clk);
                @(negedge clk);
            end
            redirect_ready = 1'b1;
            #1;
            check({tag, " redirect_valid accept"}, redirect_valid, 1'b1);
            check({tag, " redirect_pc accept"}, redirect_pc, exp_rpc);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid       = 1'b0;
        redirect_ready = 1'($urandom_range(0, 1));
        #1;
        check({tag, " redirect_valid after"}, redirect_valid, 1'b0);
        check({tag, " in_ready after"}, in_ready, 1'b1);
        check({tag, " done_valid after"}, done_valid, 1'b0);
        check({tag, " flush after"}, flush, 1'b0);
        check({tag, " branch_count"}, 32'(branch_count), 32'(exp_br));
        check({tag, " mispredict_count"}, 32'(mispredict_count), 32'(exp_mis));
        @(negedge clk);
    endtask

    initial begin
        logic        t_taken;
        logic        t_mis;
        logic [31:0] t_tgt;
        logic [31:0] r_pc;
        logic [31:0] r_imm;
        logic        r_pred;
        logic        r_jmp;
        logic        r_cmp;

        //            pc            imm           pred  jmp   cmp  hold taken flush rpc
        tbl[0] = '{32'h0000_0100, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{32'h0000_0100, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b1, 32'h0000_0120};
        tbl[2] = '{32'h0000_0200, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h0};
        tbl[3] = '{32'hFFFF_FFFC, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h0000_0000};
        tbl[4] = '{32'h0000_1000, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 32'h0000_1006};
        tbl[5] = '{32'h0000_0300, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0};

        reset          = 1'b1;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_imm         = '0;
        in_pred_taken  = 1'b0;
        in_is_jump     = 1'b0;
        cmp_result     = 1'b0;
        redirect_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset done_valid", done_valid, 1'b0);
        check("reset done_taken", done_taken, 1'b0);
        check("reset flush", flush, 1'b0);
        check("reset redirect_valid", redirect_valid, 1'b0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset branch_count", 32'(branch_count), 32'h0);
        check("reset mispredict_count", 32'(mispredict_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready after reset release", in_ready, 1'b1);
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_branch(tbl[i].pc, tbl[i].imm, tbl[i].pred, tbl[i].jmp, tbl[i].cmp,
                       tbl[i].hold, tbl[i].exp_taken, tbl[i].exp_flush, tbl[i].exp_rpc,
                       $sformatf("tbl%0d", i));
        end

        // Reset while a redirect is pending
        exp_br = 0;
        exp_mis = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h0000_0400; in_imm = 32'h0000_0080;
        in_pred_taken = 1'b0; in_is_jump = 1'b1; redirect_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cmp_result = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid redirect_valid before", redirect_valid, 1'b1);
        check("rstmid redirect_pc before", redirect_pc, 32'h0000_0480);
        check("rstmid mispredict_count before", 32'(mispredict_count), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid redirect_valid", redirect_valid, 1'b0);
        check("rstmid redirect_pc", redirect_pc, 32'h0);
        check("rstmid branch_count", 32'(branch_count), 32'h0);
        check("rstmid mispredict_count", 32'(mispredict_count), 32'h0);
        reset = 1'b0;
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        run_branch(32'h0000_0500, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0, "rstmid post");

        // Randomized branches against the model
        for (int i = 0; i < 40; i++) begin
            r_pc   = $urandom;
            r_imm  = $urandom;
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            r_pred = 1'($urandom_range(0, 1));
            r_jmp  = ($urandom_range(0, 3) == 0);
            r_cmp  = 1'($urandom_range(0, 1));
            model(r_pc, r_imm, r_pred, r_jmp, r_cmp, t_taken, t_mis, t_tgt);
            run_branch(r_pc, r_imm, r_pred, r_jmp, r_cmp, $urandom_range(0, 3),
                       t_taken, t_mis, t_tgt, $sformatf("rnd%0d", i));
        end

        // Saturation: 20 mispredicts from a clean counter state
        reset = 1'b1;
        exp_br = 0;
        exp_mis = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            r_pc  = $urandom;
            r_imm = $urandom;
            r_cmp = 1'($urandom_range(0, 1));
            model(r_pc, r_imm, ~r_cmp, 1'b0, r_cmp, t_taken, t_mis, t_tgt);
            run_branch(r_pc, r_imm, ~r_cmp, 1'b0, r_cmp, $urandom_range(0, 2),
                       t_taken, t_mis, t_tgt, $sformatf("sat%0d", i));
        end
        check("sat branch_count final", 32'(branch_count), 32'd15);
        check("sat mispredict_count final", 32'(mispredict_count), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
